vmem_arbiter: RTL and testbench
===============================

Name: vmem_arbiter

Overview:
- Shares the single-port 640x480x24 frame buffer between three users: display scan-out, a pixel writer (CPU or MMIO bridge), and a built-in clear-screen engine.
- Sits between the VGA controller's h_addr/v_addr/vga_data interface and the frame-buffer RAM.
- Display reads always win, so scan-out never stalls. The writer and the clear engine use the remaining free cycles.

Parameters:
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- AW, 19, frame-buffer address width (must satisfy 2^AW >= H_RES*V_RES)
- DW, 24, pixel width in RGB888

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_req  in  1  display read strobe, one cycle per pixel
- pix_h  in  10  display x (h_addr)
- pix_v  in  10  display y (v_addr)
- pix_data  out  DW  pixel returned to the display (vga_data)
- pix_valid  out  1  pix_data is valid this cycle
- wr_valid  in  1  writer request
- wr_ready  out  1  writer request accepted this cycle
- wr_x  in  10  write x coordinate
- wr_y  in  10  write y coordinate
- wr_data  in  DW  write pixel
- wr_err  out  1  one-cycle pulse: accepted write was out of range and dropped
- clr_start  in  1  start a full-screen fill
- clr_color  in  DW  fill colour, sampled when clr_start is accepted
- clr_busy  out  1  fill in progress
- mem_addr  out  AW  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid 1 cycle after the address

Behaviour:
- Address mapping: linear address = y*H_RES + x. For the default H_RES this is computed as (y<<9)+(y<<7)+x. No multiplier. Result is truncated to AW bits.
- Per-cycle priority: pix_req > active clear > wr_valid. Exactly one RAM access per cycle.
- Display read path:
  - Cycle N: pix_req=1 drives mem_addr and mem_we=0.
  - Cycle N+1: RAM returns data.
  - Cycle N+2: pix_data is registered and pix_valid=1.
  - Fixed latency is 2 cycles. Back-to-back pix_req is fully pipelined.
- Display out of range (pix_h>=H_RES or pix_v>=V_RES): no RAM access, and the slot is given to the next user. pix_data=0 and pix_valid=1 at N+2.
- pix_data holds its last value when pix_valid=0.
- Writer handshake:
  - wr_ready = wr_valid & ~pix_req & ~clr_busy, computed combinationally.
  - Transfer occurs on wr_valid & wr_ready.
  - An in-range write drives mem_we=1 the same cycle.
  - An out-of-range write is accepted, not written, and wr_err pulses the next cycle.
  - The writer must hold wr_x/wr_y/wr_data stable until wr_ready.
- Clear FSM:
  - IDLE -> FILL on clr_start while in IDLE; clr_color is latched and the counter is reset to 0.
  - In FILL, each cycle without pix_req writes the colour at the counter address and increments the counter.
  - When the counter reaches H_RES*V_RES-1 and that write completes, the FSM returns to IDLE.
  - clr_busy=1 for the entire FILL state, including the cycle of the last write. It drops the cycle after the last write.
  - clr_start during FILL is ignored, with no restart.
  - A full clear takes exactly 307200 write cycles plus the number of cycles stolen by pix_req.
- Simultaneous events:
  - clr_start with wr_valid in IDLE: the write proceeds this cycle and FILL starts next cycle.
  - pix_req with anything else: the display wins, and the other access retries next cycle.
- Reset values: pix_data=0, pix_valid=0, wr_err=0, clr_busy=0, FSM=IDLE, counter=0, mem_we=0.
- Reset mid-operation: an in-flight fill is abandoned, as are in-flight reads (no pix_valid after reset). RAM contents are untouched.
- mem_addr is a don't-care when idle; it is driven to 0.

Decomposition:
- Package vmem_pkg holds H_RES, V_RES, AW, DW, the FSM state enum {IDLE, FILL}, and an xy_to_addr function.
- One natural sub-module, vmem_clear_fsm: owns the fill counter, state, latched colour and clr_busy, and takes a grant input from the arbiter.

Test Plan:
1. Reset, then pix_req with (h=3,v=2) and RAM[1283]=0x123456 -> pix_valid at N+2 with pix_data=0x123456. mem_we=0 throughout.
2. Continuous pix_req every cycle plus wr_valid held -> wr_ready=0 the whole time. Drop pix_req for 1 cycle -> exactly one write to y*640+x, wr_ready=1 for one cycle.
3. Write (x=640,y=0) -> wr_ready=1, mem_we stays 0, wr_err pulses once. Write (x=639,y=479) -> mem_addr=307199, mem_we=1.
4. clr_start with colour 0xFF0000 and no display traffic -> clr_busy high for 307200 cycles, last mem_addr=307199, all RAM words = 0xFF0000. wr_ready=0 throughout.
5. Clear with pix_req every 4th cycle -> clr_busy lasts ceil(307200*4/3) cycles and pix_data is uninterrupted. A second clr_start mid-fill causes no restart.
6. Assert rst mid-fill -> next cycle clr_busy=0, pix_valid=0, mem_we=0. A new clr_start restarts the fill from address 0.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared frame-buffer geometry, clear-engine state type and the (x,y) to linear address helper.
package vmem_pkg;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int AW    = 19;
  localparam int DW    = 24;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } clr_state_e;

  // 640 = 512 + 128, so the common geometry needs only two shifts and an add.
  function automatic logic [31:0] xy_to_addr(input logic [9:0] x, input logic [9:0] y,
                                             input int unsigned h_res);
    logic [31:0] xw;
    logic [31:0] yw;
    xw = {22'd0, x};
    yw = {22'd0, y};
    if (h_res == 32'd640) return (yw << 9) + (yw << 7) + xw;
    return (yw * h_res) + xw;
  endfunction

endpackage

// File: rtl/vmem_clear_fsm.sv
// Full-screen fill engine: one colour write per granted cycle, counter runs 0..H_RES*V_RES-1.
// No added latency; a withheld grant simply stalls the counter, and start is ignored while filling.
module vmem_clear_fsm #(
  parameter int H_RES = vmem_pkg::H_RES,
  parameter int V_RES = vmem_pkg::V_RES,
  parameter int AW    = vmem_pkg::AW,
  parameter int DW    = vmem_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [DW-1:0] color_i,
  input  logic          grant_i,
  output logic          busy_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] color_o
);
  import vmem_pkg::*;

  localparam logic [AW-1:0] LAST = AW'(H_RES * V_RES - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] color_q, color_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FILL;
          cnt_d   = '0;
          color_d = color_i;
        end
      end
      FILL: begin
        if (grant_i) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o  = (state_q == FILL);
  assign addr_o  = cnt_q;
  assign color_o = color_q;

endmodule

// File: rtl/vmem_arbiter.sv
// Single-port frame-buffer arbiter: display read > clear fill > pixel writer, one RAM access per cycle.
// Display data returns 2 cycles after pix_req; writer is stalled via wr_ready while display or fill own the RAM.
module vmem_arbiter #(
  parameter int H_RES = vmem_pkg::H_RES,
  parameter int V_RES = vmem_pkg::V_RES,
  parameter int AW    = vmem_pkg::AW,
  parameter int DW    = vmem_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_req,
  input  logic [9:0]    pix_h,
  input  logic [9:0]    pix_v,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [9:0]    wr_x,
  input  logic [9:0]    wr_y,
  input  logic [DW-1:0] wr_data,
  output logic          wr_err,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  import vmem_pkg::*;

  logic [AW-1:0] pix_addr, wr_addr, clr_addr;
  logic [DW-1:0] clr_fill;
  logic          pix_oor, wr_oor, pix_rd, clr_grant, wr_we;
  logic          rd_vld_q, rd_oor_q, pix_valid_q, wr_err_q;
  logic [DW-1:0] pix_data_q;

  assign pix_addr = AW'(xy_to_addr(pix_h, pix_v, H_RES));
  assign wr_addr  = AW'(xy_to_addr(wr_x, wr_y, H_RES));
  assign pix_oor  = ({22'd0, pix_h} >= 32'(H_RES)) || ({22'd0, pix_v} >= 32'(V_RES));
  assign wr_oor   = ({22'd0, wr_x} >= 32'(H_RES)) || ({22'd0, wr_y} >= 32'(V_RES));

  // An out-of-range display request frees the slot for the fill engine.
  assign pix_rd    = pix_req & ~pix_oor & ~rst;
  assign clr_grant = clr_busy & ~pix_rd & ~rst;
  assign wr_ready  = wr_valid & ~pix_req & ~clr_busy & ~rst;
  assign wr_we     = wr_ready & ~wr_oor;

  vmem_clear_fsm #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .AW   (AW),
    .DW   (DW)
  ) u_clear (
    .clk    (clk),
    .rst    (rst),
    .start_i(clr_start),
    .color_i(clr_color),
    .grant_i(clr_grant),
    .busy_o (clr_busy),
    .addr_o (clr_addr),
    .color_o(clr_fill)
  );

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (pix_rd) begin
      mem_addr = pix_addr;
    end else if (clr_grant) begin
      mem_addr  = clr_addr;
      mem_we    = 1'b1;
      mem_wdata = clr_fill;
    end else if (wr_we) begin
      mem_addr  = wr_addr;
      mem_we    = 1'b1;
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q    <= 1'b0;
      rd_oor_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      rd_vld_q    <= pix_req;
      rd_oor_q    <= pix_oor;
      pix_valid_q <= rd_vld_q;
      if (rd_vld_q) pix_data_q <= rd_oor_q ? '0 : mem_rdata;
      wr_err_q    <= wr_ready & wr_oor;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter with a cycle-level reference model of the three-user arbitration.
module tb_vmem_arbiter;
  // Full 640-pixel lines keep the shift-based address path in play; 20 lines keep fills short.
  localparam int H_RES = 640;
  localparam int V_RES = 20;
  localparam int AW    = 19;
  localparam int DW    = 24;
  localparam int NPIX  = H_RES * V_RES;
  localparam int LIMIT = 30000;

  logic          clk, rst;
  logic          pix_req, pix_valid, wr_valid, wr_ready, wr_err, clr_start, clr_busy, mem_we;
  logic [9:0]    pix_h, pix_v, wr_x, wr_y;
  logic [DW-1:0] pix_data, wr_data, clr_color, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  vmem_arbiter #(.H_RES(H_RES), .V_RES(V_RES), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .pix_req(pix_req), .pix_h(pix_h), .pix_v(pix_v), .pix_data(pix_data), .pix_valid(pix_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_err(wr_err), .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int vectors = 0;
  int miscompares = 0;
  int printed = 0;
  bit chk_en = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (printed < 40) begin
        printed++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
    end
  endfunction

  // Reference model state
  logic [DW-1:0] model_mem [0:NPIX-1];
  bit            m_busy = 1'b0, m_err = 1'b0, m_pv1 = 1'b0, m_pv_now = 1'b0;
  int            m_cnt = 0;
  logic [DW-1:0] m_color = '0, m_pd1 = '0, m_pdata = '0;

  always @(negedge clk) begin : cmp
    bit            pin, win, e_rdy, e_we;
    int            pa, wa, e_addr;
    logic [DW-1:0] e_wd;
    pin    = (int'(pix_h) < H_RES) && (int'(pix_v) < V_RES);
    win    = (int'(wr_x) < H_RES) && (int'(wr_y) < V_RES);
    pa     = int'(pix_v) * H_RES + int'(pix_h);
    wa     = int'(wr_y) * H_RES + int'(wr_x);
    e_rdy  = !rst && wr_valid && !pix_req && !m_busy;
    e_we   = 1'b0;
    e_addr = 0;
    e_wd   = '0;
    if (rst) begin
      e_we = 1'b0;
    end else if (pix_req && pin) begin
      e_addr = pa;
    end else if (m_busy) begin
      e_we = 1'b1; e_addr = m_cnt; e_wd = m_color;
    end else if (e_rdy && win) begin
      e_we = 1'b1; e_addr = wa; e_wd = wr_data;
    end
    if (chk_en) begin
      check("wr_ready", 32'(wr_ready), 32'(e_rdy));
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_addr", 32'(mem_addr), e_addr);
      if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      check("clr_busy", 32'(clr_busy), 32'(m_busy));
      check("wr_err", 32'(wr_err), 32'(m_err));
      check("pix_valid", 32'(pix_valid), 32'(m_pv_now));
      check("pix_data", 32'(pix_data), 32'(m_pdata));
    end
    if (rst) begin
      m_busy = 1'b0; m_cnt = 0; m_err = 1'b0;
      m_pv1 = 1'b0; m_pv_now = 1'b0; m_pdata = '0;
    end else begin
      m_pv_now = m_pv1;
      if (m_pv1) m_pdata = m_pd1;
      m_pv1 = pix_req;
      m_pd1 = pin ? model_mem[pa] : '0;
      if (e_we) model_mem[e_addr] = e_wd;
      m_err = e_rdy && !win;
      if (m_busy) begin
        if (!(pix_req && pin)) begin
          if (m_cnt == NPIX - 1) m_busy = 1'b0;
          else m_cnt++;
        end
      end else if (clr_start) begin
        m_busy = 1'b1; m_cnt = 0; m_color = clr_color;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int cyc, k, cnt, bad;
  logic [AW-1:0] last_addr;

  initial begin
    rst = 1'b1; pix_req = 1'b0; pix_h = '0; pix_v = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    clr_start = 1'b0; clr_color = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    for (int i = 0; i < NPIX; i++) model_mem[i] = '0;
    ram[1283] = 24'h123456;
    model_mem[1283] = 24'h123456;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_pix_data", 32'(pix_data), 32'h0);
    check("rst_pix_valid", 32'(pix_valid), 32'h0);
    check("rst_wr_err", 32'(wr_err), 32'h0);
    check("rst_clr_busy", 32'(clr_busy), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    step();

    // Display read of (3,2) -> address 1283, data two cycles later
    pix_req = 1'b1; pix_h = 10'd3; pix_v = 10'd2;
    @(negedge clk);
    check("t1_addr", 32'(mem_addr), 32'd1283);
    check("t1_we", 32'(mem_we), 32'h0);
    step();
    pix_req = 1'b0;
    @(negedge clk);
    check("t1_valid_n1", 32'(pix_valid), 32'h0);
    step();
    @(negedge clk);
    check("t1_valid_n2", 32'(pix_valid), 32'h1);
    check("t1_data_n2", 32'(pix_data), 32'h123456);
    step();

    // Writer starved by continuous display reads, then one free slot
    wr_valid = 1'b1; wr_x = 10'd5; wr_y = 10'd7; wr_data = 24'hBEEF01;
    cnt = 0; bad = 0;
    for (int i = 0; i < 11; i++) begin
      pix_req = (i < 10); pix_h = 10'(i); pix_v = 10'd2;
      @(negedge clk);
      if (wr_ready) cnt++;
      if (mem_we) bad++;
      if (i == 10) begin
        check("t2_free_addr", 32'(mem_addr), 32'd4485);
        check("t2_free_we", 32'(mem_we), 32'h1);
      end
      step();
    end
    wr_valid = 1'b0; pix_req = 1'b0;
    check("t2_ready_cycles", 32'(cnt), 32'd1);
    check("t2_write_count", 32'(bad), 32'd1);

    // Out-of-range write: accepted, dropped, flagged next cycle
    wr_valid = 1'b1; wr_x = 10'd640; wr_y = 10'd0; wr_data = 24'h777777;
    @(negedge clk);
    check("t3_oor_ready", 32'(wr_ready), 32'h1);
    check("t3_oor_we", 32'(mem_we), 32'h0);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    check("t3_err_pulse", 32'(wr_err), 32'h1);
    step();
    @(negedge clk);
    check("t3_err_drop", 32'(wr_err), 32'h0);
    wr_valid = 1'b1; wr_x = 10'd639; wr_y = 10'(V_RES - 1); wr_data = 24'h5A5A5A;
    @(negedge clk);
    check("t3_last_addr", 32'(mem_addr), 32'd12799);
    check("t3_last_we", 32'(mem_we), 32'h1);
    step();
    wr_valid = 1'b0;
    // Read it back, then an out-of-range display read returning zero
    pix_req = 1'b1; pix_h = 10'd639; pix_v = 10'(V_RES - 1);
    step();
    pix_h = 10'd700; pix_v = 10'd0;
    @(negedge clk);
    check("t3_oor_pix_we", 32'(mem_we), 32'h0);
    step();
    pix_req = 1'b0;
    @(negedge clk);
    check("t3_readback", 32'(pix_data), 32'h5A5A5A);
    step();
    @(negedge clk);
    check("t3_oor_pix_valid", 32'(pix_valid), 32'h1);
    check("t3_oor_pix_data", 32'(pix_data), 32'h0);
    step();

    // Full clear, writer held the whole time
    clr_start = 1'b1; clr_color = 24'hFF0000;
    wr_valid = 1'b1; wr_x = 10'd1; wr_y = 10'd1; wr_data = 24'h00ABCD;
    step();
    clr_start = 1'b0;
    cyc = 0; cnt = 0; last_addr = '0;
    while (cyc < LIMIT) begin
      @(negedge clk);
      if (!clr_busy) break;
      if (wr_ready) cnt++;
      if (mem_we) last_addr = mem_addr;
      cyc++;
      step();
    end
    check("t4_busy_cycles", 32'(cyc), 32'd12800);
    check("t4_last_addr", 32'(last_addr), 32'd12799);
    check("t4_ready_during_fill", 32'(cnt), 32'd0);
    check("t4_ready_after_fill", 32'(wr_ready), 32'h1);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (ram[i] !== 24'hFF0000) bad++;
    check("t4_ram_filled", 32'(bad), 32'd0);
    step();
    wr_valid = 1'b0;
    step();

    // Clear with a display read every 4th cycle and an ignored restart
    clr_start = 1'b1; clr_color = 24'h0000FF;
    step();
    clr_start = 1'b0;
    k = 0;
    while (k < LIMIT) begin
      pix_req = (k % 4 == 0); pix_h = 10'(k % 640); pix_v = 10'((k / 640) % V_RES);
      clr_start = (k == 100); clr_color = 24'h00FF00;
      @(negedge clk);
      if (!clr_busy) break;
      k++;
      step();
    end
    pix_req = 1'b0; clr_start = 1'b0;
    check("t5_busy_cycles", 32'(k), 32'd17067);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (ram[i] !== 24'h0000FF) bad++;
    check("t5_ram_filled", 32'(bad), 32'd0);
    step();
    step();

    // Reset mid-fill with a read in flight, then a fresh fill from address 0
    clr_start = 1'b1; clr_color = 24'h0000AA;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      pix_req = (i == 48); pix_h = 10'd1; pix_v = 10'd1;
      rst = (i == 49);
      step();
    end
    rst = 1'b0; pix_req = 1'b0;
    @(negedge clk);
    check("t6_busy_after_rst", 32'(clr_busy), 32'h0);
    check("t6_valid_after_rst", 32'(pix_valid), 32'h0);
    check("t6_we_after_rst", 32'(mem_we), 32'h0);
    clr_start = 1'b1; clr_color = 24'h0000AA;
    step();
    clr_start = 1'b0;
    @(negedge clk);
    check("t6_restart_addr", 32'(mem_addr), 32'd0);
    check("t6_restart_we", 32'(mem_we), 32'h1);
    check("t6_restart_data", 32'(mem_wdata), 32'h0000AA);
    step();
    @(negedge clk);
    check("t6_second_addr", 32'(mem_addr), 32'd1);
    step();
    rst = 1'b1;
    step();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
